// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for an external unsigned XLEN x XLEN multiplier core.
// Optional last-operand reuse store enabled by defining MUL_REUSE_EN.
module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [XLEN-1:0]   result_o,
  output logic              result_valid_o,
  output logic              mul_start_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  input  logic [2*XLEN-1:0] mul_product_i,
  input  logic              mul_done_i
);

  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, RESP} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic            neg_q;
  logic [W2-1:0]   p_q;

  // Operand signedness: A signed unless MULHU, B signed only for MUL/MULH.
  logic            sgn_a, sgn_b, a_neg, b_neg, neg_d;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [W2-1:0]   p_fix;

  always_comb begin
    sgn_a = (op_i != 2'b11);
    sgn_b = ~op_i[1];
    a_neg = sgn_a & rs1_i[XLEN-1];
    b_neg = sgn_b & rs2_i[XLEN-1];
    neg_d = a_neg ^ b_neg;
    mag_a = a_neg ? -rs1_i : rs1_i;
    mag_b = b_neg ? -rs2_i : rs2_i;
    p_fix = neg_q ? (~mul_product_i) + W2'(1) : mul_product_i;
  end

  assign ready_o = (state == IDLE) & ~flush_i;
  assign busy_o  = (state != IDLE);

`ifdef MUL_REUSE_EN
  logic [XLEN-1:0] rs1_q, rs2_q, st_rs1, st_rs2;
  logic [1:0]      mode_q, st_mode;
  logic [W2-1:0]   st_p;
  logic            st_vld, hit;

  assign hit = st_vld & (rs1_i == st_rs1) & (rs2_i == st_rs2) &
               ({sgn_a, sgn_b} == st_mode);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      op_q           <= '0;
      neg_q          <= 1'b0;
      p_q            <= '0;
      mul_a_o        <= '0;
      mul_b_o        <= '0;
      mul_start_o    <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
`ifdef MUL_REUSE_EN
      rs1_q          <= '0;
      rs2_q          <= '0;
      mode_q         <= '0;
      st_rs1         <= '0;
      st_rs2         <= '0;
      st_mode        <= '0;
      st_p           <= '0;
      st_vld         <= 1'b0;
`endif
    end else begin
      mul_start_o    <= 1'b0;
      result_valid_o <= 1'b0;
      if (flush_i) begin
        // Late mul_done_i after a kill lands in IDLE and is dropped there.
        state <= IDLE;
`ifdef MUL_REUSE_EN
        st_vld <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: if (valid_i) begin
            op_q    <= op_i;
            neg_q   <= neg_d;
            mul_a_o <= mag_a;
            mul_b_o <= mag_b;
`ifdef MUL_REUSE_EN
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
            mode_q  <= {sgn_a, sgn_b};
            if (hit) begin
              p_q   <= st_p;
              state <= FIX;
            end else begin
              mul_start_o <= 1'b1;
              state       <= BUSY;
            end
`else
            mul_start_o <= 1'b1;
            state       <= BUSY;
`endif
          end
          BUSY: if (mul_done_i) begin
            p_q   <= p_fix;
            state <= FIX;
`ifdef MUL_REUSE_EN
            st_rs1  <= rs1_q;
            st_rs2  <= rs2_q;
            st_mode <= mode_q;
            st_p    <= p_fix;
            st_vld  <= 1'b1;
`endif
          end
          FIX: begin
            result_o       <= (op_q == 2'b00) ? p_q[XLEN-1:0] : p_q[W2-1:XLEN];
            result_valid_o <= 1'b1;
            state          <= RESP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural multiplier core of
// programmable latency; reuse expectations follow MUL_REUSE_EN.
module tb_mul_seq_ctrl;
  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              valid_i = 1'b0;
  logic [1:0]        op_i = 2'b00;
  logic [XLEN-1:0]   rs1_i = '0;
  logic [XLEN-1:0]   rs2_i = '0;
  logic              flush_i = 1'b0;
  logic              ready_o, busy_o, result_valid_o, mul_start_o, mul_done_i;
  logic [XLEN-1:0]   result_o, mul_a_o, mul_b_o;
  logic [2*XLEN-1:0] mul_product_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mul_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .ready_o(ready_o),
    .busy_o(busy_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_product_i(mul_product_i), .mul_done_i(mul_done_i)
  );

  // Core model: done strobes core_lat cycles after the start pulse.
  int          core_lat = 1;
  int          cnt = 0;
  logic [63:0] prod_r = '0;
  always @(posedge clk_i) begin
    if (mul_start_o) begin
      cnt    <= core_lat;
      prod_r <= 64'(mul_a_o) * 64'(mul_b_o);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end
  assign mul_done_i    = (cnt == 1);
  assign mul_product_i = prod_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int              starts = 0;
  int              vcnt = 0;
  logic [XLEN-1:0] st_a = '0, st_b = '0;
  always @(negedge clk_i) begin
    if (mul_start_o) begin
      starts <= starts + 1;
      st_a   <= mul_a_o;
      st_b   <= mul_b_o;
    end
    if (result_valid_o) vcnt <= vcnt + 1;
  end

  // Core operands must not move while the core is working.
  always @(negedge clk_i) begin
    if (mul_done_i && busy_o && rst_ni) begin
      chk("hold_a", 64'(mul_a_o), 64'(st_a));
      chk("hold_b", 64'(mul_b_o), 64'(st_b));
    end
  end

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input int exp_starts, input int exp_lat);
    int s0, n;
    @(negedge clk_i);
    s0 = starts;
    chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 1;
    while (!result_valid_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result_o), 64'(exp_r));
    @(negedge clk_i);
    chk({tag, "_pulse"}, 64'(result_valid_o), 64'd0);
    chk({tag, "_starts"}, 64'(starts - s0), 64'(exp_starts));
  endtask

  initial begin
    int s0, v0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rv", 64'(result_valid_o), 64'd0);
    chk("rst_res", 64'(result_o), 64'd0);
    chk("rst_start", 64'(mul_start_o), 64'd0);
    chk("rst_a", 64'(mul_a_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 64'(ready_o), 64'd1);

    core_lat = 1;
    run_op("mul76", 2'b00, 32'd7, 32'd6, 32'h0000002A, 1, 4);
    chk("mul76_a", 64'(st_a), 64'd7);
    chk("mul76_b", 64'(st_b), 64'd6);

    core_lat = 3;
    run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1, 6);
    chk("mulh_min_a", 64'(st_a), 64'h80000000);

    core_lat = 2;
    run_op("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5);
    chk("mulhsu_a", 64'(st_a), 64'd1);
    chk("mulhsu_b", 64'(st_b), 64'hFFFFFFFF);
    run_op("mulhu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 5);
    run_op("mul_min", 2'b00, 32'h80000000, 32'd1, 32'h80000000, 1, 5);

    run_op("reuse_h", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1, 5);
`ifdef MUL_REUSE_EN
    run_op("reuse_l", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 0, 2);
`else
    run_op("reuse_l", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1, 5);
`endif

    // Kill an op in BUSY; the core's late done must not produce a result.
    core_lat = 4;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 2'b01; rs1_i = 32'd5; rs2_i = 32'd5;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("fl_busy", 64'(busy_o), 64'd1);
    v0 = vcnt;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("fl_idle", 64'(busy_o), 64'd0);
    repeat (8) @(negedge clk_i);
    chk("fl_norv", 64'(vcnt - v0), 64'd0);
    run_op("mul33", 2'b00, 32'd3, 32'd3, 32'h00000009, 1, 7);

    // Flush beats valid in the same IDLE cycle.
    @(negedge clk_i);
    s0 = starts;
    valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; rs1_i = 32'd1; rs2_i = 32'd1;
    #1 chk("vf_ready", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("vf_busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk_i);
    chk("vf_starts", 64'(starts - s0), 64'd0);

    // Reset mid-operation abandons the op.
    core_lat = 3;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    v0 = vcnt;
    rst_ni = 1'b0;
    #1;
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_a", 64'(mul_a_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk_i);
    chk("mr_norv", 64'(vcnt - v0), 64'd0);
    run_op("mul23", 2'b00, 32'd2, 32'd3, 32'h00000006, 1, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
